// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. It decodes sync, display enable,
// line/frame strobes and a test-pattern colour from the raster counters into one output register stage.
module vga_timing_gen #(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 56,
    parameter int H_SYNC = 120,
    parameter int H_BP   = 64,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 37,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 23,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1,
    parameter int CW     = 11,
    parameter int CDW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic [1:0]       mode,
    input  logic [3*CDW-1:0] rgb_in,
    output logic [CW-1:0]    x,
    output logic [CW-1:0]    y,
    output logic [CDW-1:0]   r,
    output logic [CDW-1:0]   g,
    output logic [CDW-1:0]   b,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_last, v_last;

    assign h_last = (h_cnt == CW'(H_TOTAL - 1));
    assign v_last = (v_cnt == CW'(V_TOTAL - 1));
    assign x      = h_cnt;
    assign y      = v_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    logic           vis_d, hs_act, vs_act;
    logic [2:0]     bar_k;
    logic [CDW-1:0] r_d, g_d, b_d;

    // Bar index floor(x*8/H_VIS): x*8 is a shift, compared against constant multiples of H_VIS.
    always_comb begin
        bar_k = 3'd0;
        for (int j = 1; j < 8; j++) begin
            if ({h_cnt, 3'b000} >= (CW+3)'(j * H_VIS))
                bar_k = bar_k + 3'd1;
        end
    end

    always_comb begin
        vis_d  = (h_cnt < CW'(H_VIS)) && (v_cnt < CW'(V_VIS));
        hs_act = (h_cnt >= CW'(H_VIS + H_FP)) && (h_cnt < CW'(H_VIS + H_FP + H_SYNC));
        vs_act = (v_cnt >= CW'(V_VIS + V_FP)) && (v_cnt < CW'(V_VIS + V_FP + V_SYNC));
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (vis_d) begin
            case (mode)
                2'd0: {r_d, g_d, b_d} = rgb_in;
                2'd1: {r_d, g_d, b_d} = '1;
                2'd2: begin
                    r_d = {CDW{bar_k[2]}};
                    g_d = {CDW{bar_k[1]}};
                    b_d = {CDW{bar_k[0]}};
                end
                default: {r_d, g_d, b_d} = {(3*CDW){h_cnt[4] ^ v_cnt[4]}};
            endcase
        end
    end

    // Strobes fall on idle pix_en cycles so each stays one clk wide; everything else holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de          <= 1'b0;
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            r           <= r_d;
            g           <= g_d;
            b           <= b_d;
            de          <= vis_d;
            h_sync      <= hs_act ? HS_POL : ~HS_POL;
            v_sync      <= vs_act ? VS_POL : ~VS_POL;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster, with a per-pixel arithmetic model
// and directed frame-period, pix_en-toggle and mid-frame reset runs.
module tb_vga_timing_gen;
    localparam int H_VIS = 40, H_FP = 4, H_SYNC = 6, H_BP = 5;
    localparam int V_VIS = 20, V_FP = 2, V_SYNC = 3, V_BP = 2;
    localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
    localparam int CW = 11, CDW = 4;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic             clk = 1'b0;
    logic             rst_n, pix_en;
    logic [1:0]       mode;
    logic [3*CDW-1:0] rgb_in;
    logic [CW-1:0]    x, y;
    logic [CDW-1:0]   r, g, b;
    logic             h_sync, v_sync, de, line_start, frame_start;

    vga_timing_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .CDW(CDW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode), .rgb_in(rgb_in),
        .x(x), .y(y), .r(r), .g(g), .b(b), .h_sync(h_sync), .v_sync(v_sync),
        .de(de), .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int px = 0, py = 0;
    logic [CDW-1:0] e_r, e_g, e_b;
    logic e_de, e_hs, e_vs, e_ls, e_fs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (pos %0d,%0d)", tag, obs, exp, px, py);
        end
    endtask

    // Reference: what the pixel at the model position should look like, then advance.
    task automatic model();
        int k;
        logic [CDW-1:0] all1;
        all1 = '1;
        if (!rst_n) begin
            px = 0; py = 0;
            {e_r, e_g, e_b} = '0;
            e_de = 0; e_hs = ~HS_POL; e_vs = ~VS_POL; e_ls = 0; e_fs = 0;
        end else if (pix_en) begin
            e_de = (px < H_VIS) && (py < V_VIS);
            e_hs = (px >= H_VIS + H_FP && px < H_VIS + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
            e_vs = (py >= V_VIS + V_FP && py < V_VIS + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
            e_ls = (px == 0);
            e_fs = (px == 0) && (py == 0);
            k = (px * 8) / H_VIS;
            if (!e_de) {e_r, e_g, e_b} = '0;
            else case (mode)
                2'd0: {e_r, e_g, e_b} = rgb_in;
                2'd1: {e_r, e_g, e_b} = {all1, all1, all1};
                2'd2: begin
                    e_r = (k & 4) != 0 ? all1 : '0;
                    e_g = (k & 2) != 0 ? all1 : '0;
                    e_b = (k & 1) != 0 ? all1 : '0;
                end
                default: {e_r, e_g, e_b} = ((((px / 16) + (py / 16)) % 2) == 1) ? {all1, all1, all1} : '0;
            endcase
            px = px + 1;
            if (px == H_TOTAL) begin
                px = 0;
                py = (py + 1) % V_TOTAL;
            end
        end else begin
            e_ls = 0; e_fs = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("pos", {x, y}, {CW'(px), CW'(py)});
        chk("out", {r, g, b, de, h_sync, v_sync, line_start, frame_start},
                   {e_r, e_g, e_b, e_de, e_hs, e_vs, e_ls, e_fs});
    endtask

    task automatic run_to_fs(input bit toggle, input int limit, output int nstep, output int nls);
        nstep = 0; nls = 0;
        do begin
            if (toggle) pix_en = ~pix_en;
            step();
            nstep++;
            if (line_start && !frame_start) nls++;
        end while (!frame_start && nstep < limit);
        if (!frame_start) chk("fs_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int ns, nl;
        rst_n = 0; pix_en = 0; mode = 0; rgb_in = 12'hABC;
        step(); step();
        chk("rst_de", {63'd0, de}, 64'd0);
        chk("rst_hs", {63'd0, h_sync}, {63'd0, ~HS_POL});

        // First pixel after reset is (0,0) with both strobes.
        rst_n = 1; pix_en = 1;
        step();
        chk("first_fs", {62'd0, frame_start, line_start}, 64'd3);
        chk("first_rgb", {r, g, b}, 64'hABC);

        mode = 2;
        run_to_fs(1'b0, 2 * FRAME, ns, nl);
        chk("period", ns, FRAME);
        chk("lines", nl + 1, V_TOTAL);

        mode = 3;
        run_to_fs(1'b1, 3 * FRAME, ns, nl);
        chk("period_half", ns, 2 * FRAME);
        chk("lines_half", nl + 1, V_TOTAL);

        // Random pixels: mode, colour, enable and rare resets.
        pix_en = 1;
        for (int i = 0; i < 5000; i++) begin
            pix_en = ($urandom % 4) != 0;
            if ($urandom % 64 == 0) mode = 2'($urandom);
            rgb_in = 12'($urandom);
            rst_n = ($urandom % 700) != 0;
            step();
        end

        // Mid-frame reset, then restart from (0,0).
        rst_n = 1; pix_en = 1; mode = 0; rgb_in = 12'hABC;
        for (int i = 0; i < 3 * FRAME && !(px == 30 && py == 10); i++) step();
        chk("reach_mid", px * 1000 + py, 30010);
        rst_n = 0;
        step();
        chk("mid_rst", {x, y, r, g, b, de, line_start, frame_start}, 64'd0);
        rst_n = 1;
        step();
        chk("restart_fs", {62'd0, frame_start, de}, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator with registered RGB output stage.
- Replaces the fixed 800x600 counter pair in the display path.
- Timing, sync polarity and colour depth are set by parameters; a pixel-clock enable allows reuse across clock rates.
- Provides pixel-request coordinates, line/frame strobes and built-in test patterns. Sits between the pixel source (frame logic) and the VGA pins.

Parameters:
H_VIS, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels)
V_VIS, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, active level of h_sync
VS_POL, 1, active level of v_sync
CW, 11, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
CDW, 4, bits per colour channel

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pix_en  in  1  pixel advance enable (tie 1 for one pixel per clk)
mode  in  2  0 = rgb_in passthrough, 1 = solid white, 2 = colour bars, 3 = checkerboard
rgb_in  in  3*CDW  {r,g,b} for the pixel at (x,y); sampled on pix_en cycles
x  out  CW  request column = h_cnt
y  out  CW  request row = v_cnt
r, g, b  out  CDW each  registered colour
h_sync  out  1  registered horizontal sync
v_sync  out  1  registered vertical sync
de  out  1  registered display enable
line_start  out  1  one-clk pulse, pixel 0 of any line emitted
frame_start  out  1  one-clk pulse, pixel (0,0) emitted

Behaviour:
- Timing: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (default 1040); V_TOTAL likewise (default 666).
- Line order: visible, front porch, sync, back porch.
- Counters:
  - h_cnt and v_cnt are registers, reset to 0, and advance only when pix_en=1.
  - h_cnt wraps H_TOTAL-1 -> 0. v_cnt increments on h wrap and wraps V_TOTAL-1 -> 0 on the same edge as the h wrap.
- Output stage: on each clk with pix_en=1, all outputs register the decode of the current (h_cnt, v_cnt, rgb_in, mode), then the counters advance. Latency is one pix_en from request (x,y) to emitted pixel.
- Decode:
  - de = h_cnt<H_VIS && v_cnt<V_VIS.
  - h_sync = HS_POL while H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, else ~HS_POL.
  - v_sync = VS_POL while V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC, else ~VS_POL. v_sync changes only at h wrap.
  - line_start = (h_cnt==0). frame_start = (h_cnt==0 && v_cnt==0).
- Colour (forced 0 when de=0):
  - mode 0: rgb_in.
  - mode 1: all channels all-ones.
  - mode 2: k = floor(x*8/H_VIS), k in 0..7; r, g, b all-ones iff k[2], k[1], k[0] respectively. No runtime divider; use a bar counter or constant compares.
  - mode 3: all-ones on all channels iff x[4]^y[4], else 0.
- mode and rgb_in are sampled per pixel; a change applies to the next emitted pixel.
- pix_en=0:
  - Counters and the colour, sync and de outputs hold.
  - line_start and frame_start are driven 0, so each strobe is high for exactly one clk.
- Reset:
  - Values: counters 0; x=y=0; r=g=b=0; de=0; h_sync=~HS_POL; v_sync=~VS_POL; strobes 0.
  - Reset wins over pix_en. Reset mid-frame restarts at (0,0).
  - The first pix_en after reset emits pixel (0,0) with de=1 and both strobes 1.

Test Plan:
- Defaults, pix_en=1, reset then 1040*666 clks -> exactly one frame_start and 666 line_start pulses. Second frame_start arrives 692640 clks after the first.
- Defaults, line 0 -> h_sync=1 for emitted pixels 856..975 (120 clks), 0 elsewhere. de=1 for pixels 0..799 only.
- Defaults -> v_sync=1 for lines 637..642 (6 lines). de=0 on all pixels of lines 600..665.
- mode=2 -> pixels 0..99 emit rgb=000, 100..199 emit b=F, r=g=0, 700..799 emit r=g=b=F. Pixels 800+ emit 0.
- pix_en toggling 1/0 every clk -> counters advance every second clk, strobes are 1 clk wide, and the frame takes 1385280 clks.
- rst_n=0 for one clk at h_cnt=500, v_cnt=300 -> next clk outputs are reset values. The next pix_en emits (0,0) with frame_start=1. Mode 0 with rgb_in=0xABC yields r=A, g=B, b=C on visible pixels.
